// File: rtl/acc_alu_pkg.sv
// Shared opcodes, sequencer states and shift kinds for the accumulator ALU.
package acc_alu_pkg;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_XOR = 5'h05;
  localparam logic [4:0] OP_NOT = 5'h06;
  localparam logic [4:0] OP_CMP = 5'h07;
  localparam logic [4:0] OP_SLT = 5'h08;
  localparam logic [4:0] OP_SHL = 5'h09;
  localparam logic [4:0] OP_SHR = 5'h0A;
  localparam logic [4:0] OP_ASR = 5'h0B;
  localparam logic [4:0] OP_MUL = 5'h0C;
  localparam logic [4:0] OP_MFH = 5'h0D;
  localparam logic [4:0] OP_INC = 5'h0E;
  localparam logic [4:0] OP_DEC = 5'h0F;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL} state_e;
  typedef enum logic [1:0] {SH_LEFT, SH_RIGHT, SH_ARITH} shift_e;

  function automatic logic is_shift_op(input logic [4:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/acc_alu_if.sv
// Bus-side request/response bundle of the accumulator ALU.
interface acc_alu_if #(parameter int WIDTH = 16);
  logic [4:0]       opcode;
  logic [WIDTH-1:0] operand;
  logic             exec;
  logic             write;
  logic             writeu;
  logic             read;
  logic             busy;
  logic [WIDTH-1:0] accout;
  logic             flag;

  modport master (output opcode, operand, exec, write, writeu, read,
                  input  busy, accout, flag);
  modport slave  (input  opcode, operand, exec, write, writeu, read,
                  output busy, accout, flag);
endinterface

// File: rtl/acc_alu_seq.sv
// Iterative sequencer: one-bit-per-cycle shift stepping and shift-add multiply.
module acc_alu_seq
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_shift,
  input  logic                       start_mul,
  input  shift_e                     shift_kind,
  input  logic [$clog2(WIDTH)-1:0]   shift_cnt,
  input  logic [WIDTH-1:0]           mul_a,
  input  logic [WIDTH-1:0]           mul_b,
  output logic                       busy,
  output logic                       shift_step,
  output shift_e                     step_kind,
  output logic                       mul_done,
  output logic [2*WIDTH-1:0]         mul_prod
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  shift_e             kind_q, kind_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_next;

  // Upper half accumulates the multiplicand; the multiplier drains out of the low half.
  assign psum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_next = {psum, prod_q[WIDTH-1:1]};

  assign busy      = (state_q != ST_IDLE);
  assign step_kind = kind_q;
  assign mul_prod  = prod_next;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_d     = kind_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    shift_step = 1'b0;
    mul_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_shift) begin
          state_d = ST_SHIFT;
          cnt_d   = {1'b0, shift_cnt};
          kind_d  = shift_kind;
        end else if (start_mul) begin
          state_d = ST_MUL;
          cnt_d   = CNTW'(WIDTH);
          mcand_d = mul_b;
          prod_d  = {{WIDTH{1'b0}}, mul_a};
        end
      end
      ST_SHIFT: begin
        shift_step = 1'b1;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) state_d = ST_IDLE;
      end
      ST_MUL: begin
        prod_d = prod_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNTW'(1)) begin
          state_d  = ST_IDLE;
          mul_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kind_q  <= SH_LEFT;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

endmodule

// File: rtl/acc_alu.sv
// Accumulator ALU: acc/hi/flag/accout registers and single-cycle op mux;
// multi-bit shifts and multiply are delegated to acc_alu_seq.
module acc_alu
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  acc_alu_if.slave   bus
);

  localparam int CNTW = $clog2(WIDTH) + 1;
  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             flag_q, flag_d;
  logic [WIDTH-1:0] accout_q, accout_d;

  logic               busy, idle;
  logic               do_write, do_writeu, do_exec;
  logic               start_shift, start_mul;
  logic [CNTW-2:0]    shift_cnt;
  shift_e             shift_kind, step_kind;
  logic               shift_step, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     add_r, sub_r, inc_r, dec_r;

  assign idle      = !busy;
  assign do_write  = idle && bus.write;
  assign do_writeu = idle && !bus.write && bus.writeu;
  assign do_exec   = idle && !bus.write && !bus.writeu && bus.exec;
  assign shift_cnt = bus.operand[CNTW-2:0];

  // A zero-count shift never enters the sequencer; it completes here with flag cleared.
  assign start_shift = do_exec && is_shift_op(bus.opcode) && (shift_cnt != '0);
  assign start_mul   = do_exec && (bus.opcode == OP_MUL);

  assign add_r = {1'b0, acc_q} + {1'b0, bus.operand};
  assign sub_r = {1'b0, acc_q} - {1'b0, bus.operand};
  assign inc_r = {1'b0, acc_q} + 1'b1;
  assign dec_r = {1'b0, acc_q} - 1'b1;

  always_comb begin
    shift_kind = SH_ARITH;
    if (bus.opcode == OP_SHL)      shift_kind = SH_LEFT;
    else if (bus.opcode == OP_SHR) shift_kind = SH_RIGHT;
  end

  acc_alu_seq #(.WIDTH(WIDTH)) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_shift (start_shift),
    .start_mul   (start_mul),
    .shift_kind  (shift_kind),
    .shift_cnt   (shift_cnt),
    .mul_a       (acc_q),
    .mul_b       (bus.operand),
    .busy        (busy),
    .shift_step  (shift_step),
    .step_kind   (step_kind),
    .mul_done    (mul_done),
    .mul_prod    (mul_prod)
  );

  always_comb begin
    acc_d    = acc_q;
    hi_d     = hi_q;
    flag_d   = flag_q;
    accout_d = (idle && bus.read) ? acc_q : accout_q;
    if (do_write) begin
      acc_d = bus.operand;
    end else if (do_writeu) begin
      acc_d = {bus.operand[HALF-1:0], acc_q[HALF-1:0]};
    end else if (do_exec) begin
      case (bus.opcode)
        OP_ADD: begin acc_d = add_r[WIDTH-1:0]; flag_d = add_r[WIDTH]; end
        OP_SUB: begin acc_d = sub_r[WIDTH-1:0]; flag_d = sub_r[WIDTH]; end
        OP_AND: begin acc_d = acc_q & bus.operand; flag_d = ((acc_q & bus.operand) == '0); end
        OP_OR:  begin acc_d = acc_q | bus.operand; flag_d = ((acc_q | bus.operand) == '0); end
        OP_XOR: begin acc_d = acc_q ^ bus.operand; flag_d = ((acc_q ^ bus.operand) == '0); end
        OP_NOT: acc_d = ~acc_q;
        OP_CMP: flag_d = (acc_q == bus.operand);
        OP_SLT: flag_d = (acc_q < bus.operand);
        OP_SHL, OP_SHR, OP_ASR: if (shift_cnt == '0) flag_d = 1'b0;
        OP_MFH: acc_d = hi_q;
        OP_INC: begin acc_d = inc_r[WIDTH-1:0]; flag_d = inc_r[WIDTH]; end
        OP_DEC: begin acc_d = dec_r[WIDTH-1:0]; flag_d = dec_r[WIDTH]; end
        default: ;
      endcase
    end else if (shift_step) begin
      case (step_kind)
        SH_LEFT:  begin acc_d = {acc_q[WIDTH-2:0], 1'b0}; flag_d = acc_q[WIDTH-1]; end
        SH_RIGHT: begin acc_d = {1'b0, acc_q[WIDTH-1:1]}; flag_d = acc_q[0]; end
        default:  begin acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}; flag_d = acc_q[0]; end
      endcase
    end else if (mul_done) begin
      {hi_d, acc_d} = mul_prod;
      flag_d        = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      hi_q     <= '0;
      flag_q   <= 1'b0;
      accout_q <= '0;
    end else begin
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      flag_q   <= flag_d;
      accout_q <= accout_d;
    end
  end

  assign bus.busy   = busy;
  assign bus.accout = accout_q;
  assign bus.flag   = flag_q;

endmodule

// File: tb/tb_acc_alu.sv
// Self-checking bench for acc_alu against an arithmetic reference model.
module tb_acc_alu;
  localparam int     W     = 16;
  localparam int     CW    = $clog2(W) + 1;
  localparam longint MASK  = (longint'(1) << W) - 1;
  localparam longint HMASK = (longint'(1) << (W / 2)) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_alu_if #(.WIDTH(W)) bus ();
  acc_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int     checks = 0;
  int     errors = 0;
  longint m_acc, m_hi, m_accout;
  bit     m_flag;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.opcode = '0; bus.operand = '0; bus.exec = 1'b0;
    bus.write = 1'b0; bus.writeu = 1'b0; bus.read = 1'b0;
  endtask

  task automatic model_reset();
    m_acc = 0; m_hi = 0; m_accout = 0; m_flag = 0;
  endtask

  // Reference: returns the number of busy cycles the operation should take.
  function automatic int model_exec(input int opc, input longint opnd);
    longint a = m_acc, b = opnd & MASK, r, sa;
    int n = int'(b % (longint'(1) << (CW - 1)));
    int cyc = 0;
    case (opc)
      1:  begin r = a + b; m_flag = (r > MASK); m_acc = r & MASK; end
      2:  begin m_flag = (a < b); m_acc = (a - b) & MASK; end
      3:  begin m_acc = a & b; m_flag = (m_acc == 0); end
      4:  begin m_acc = a | b; m_flag = (m_acc == 0); end
      5:  begin m_acc = a ^ b; m_flag = (m_acc == 0); end
      6:  m_acc = (~a) & MASK;
      7:  m_flag = (a == b);
      8:  m_flag = (a < b);
      9, 10, 11: begin
        if (n == 0) m_flag = 0;
        else begin
          cyc = n;
          if (opc == 9) begin
            m_flag = ((a >> (W - n)) & 1) != 0;
            m_acc  = (a << n) & MASK;
          end else begin
            m_flag = ((a >> (n - 1)) & 1) != 0;
            sa = (opc == 11 && a >= (longint'(1) << (W - 1))) ? a - (longint'(1) << W) : a;
            m_acc = (sa >>> n) & MASK;
          end
        end
      end
      12: begin r = a * b; m_hi = r >> W; m_acc = r & MASK; m_flag = (m_hi != 0); cyc = W; end
      13: m_acc = m_hi;
      14: begin r = a + 1; m_flag = (r > MASK); m_acc = r & MASK; end
      15: begin m_flag = (a == 0); m_acc = (a - 1) & MASK; end
      default: ;
    endcase
    return cyc;
  endfunction

  task automatic do_exec(input int opc, input logic [W-1:0] opnd, output int cyc_seen, output int cyc_exp);
    bus.opcode = 5'(opc); bus.operand = opnd; bus.exec = 1'b1;
    cyc_exp = model_exec(opc, longint'(opnd));
    tick();
    bus.exec = 1'b0;
    cyc_seen = 0;
    while (bus.busy === 1'b1 && cyc_seen < 3 * W) begin
      cyc_seen++;
      tick();
    end
  endtask

  task automatic do_write(input logic [W-1:0] v);
    bus.operand = v; bus.write = 1'b1; m_acc = longint'(v);
    tick();
    bus.write = 1'b0;
  endtask

  task automatic do_writeu(input logic [W-1:0] v);
    bus.operand = v; bus.writeu = 1'b1;
    m_acc = ((longint'(v) & HMASK) << (W / 2)) | (m_acc & HMASK);
    tick();
    bus.writeu = 1'b0;
  endtask

  task automatic do_read();
    bus.read = 1'b1; m_accout = m_acc;
    tick();
    bus.read = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.accout !== '0) begin errors++; $display("FAIL reset_accout got %h want 0000", bus.accout); end
    checks++; if (bus.flag !== 1'b0) begin errors++; $display("FAIL reset_flag got %b want 0", bus.flag); end
    #2 rst_n = 1'b1;
    tick();
    do_read();
    checks++; if (bus.accout !== '0) begin errors++; $display("FAIL reset_acc got %h want 0000", bus.accout); end
  endtask

  task automatic test_sub_inc();
    int s, e;
    do_write(16'hfffe);
    do_exec(2, 16'h0005, s, e);
    checks++; if (s !== 0) begin errors++; $display("FAIL sub_busy got %0d want 0", s); end
    do_read();
    checks++; if (bus.accout !== 16'hfff9 || bus.flag !== 1'b0) begin errors++;
      $display("FAIL sub_result got %h/%b want fff9/0", bus.accout, bus.flag); end
    do_write(16'hffff);
    do_exec(14, 16'h0000, s, e);
    do_read();
    checks++; if (bus.accout !== 16'h0000 || bus.flag !== 1'b1) begin errors++;
      $display("FAIL inc_wrap got %h/%b want 0000/1", bus.accout, bus.flag); end
  endtask

  task automatic test_mul();
    int s, e;
    do_write(16'h1234);
    do_exec(12, 16'h0010, s, e);
    checks++; if (s !== 16) begin errors++; $display("FAIL mul_busy got %0d want 16", s); end
    do_read();
    checks++; if (bus.accout !== 16'h2340 || bus.flag !== 1'b1) begin errors++;
      $display("FAIL mul_lo got %h/%b want 2340/1", bus.accout, bus.flag); end
    do_exec(13, 16'h0000, s, e);
    do_read();
    checks++; if (bus.accout !== 16'h0001 || bus.flag !== 1'b1) begin errors++;
      $display("FAIL mfh got %h/%b want 0001/1", bus.accout, bus.flag); end
  endtask

  task automatic test_shift();
    int s, e;
    do_write(16'h8001);
    do_exec(9, 16'h0001, s, e);
    checks++; if (s !== 1) begin errors++; $display("FAIL shl1_busy got %0d want 1", s); end
    do_read();
    checks++; if (bus.accout !== 16'h0002 || bus.flag !== 1'b1) begin errors++;
      $display("FAIL shl1 got %h/%b want 0002/1", bus.accout, bus.flag); end
    do_exec(9, 16'h0000, s, e);
    do_read();
    checks++; if (s !== 0 || bus.accout !== 16'h0002 || bus.flag !== 1'b0) begin errors++;
      $display("FAIL shl0 got %0d/%h/%b want 0/0002/0", s, bus.accout, bus.flag); end
    do_write(16'h8000);
    do_exec(11, 16'h0004, s, e);
    do_read();
    checks++; if (s !== 4 || bus.accout !== 16'hf800 || bus.flag !== 1'b0) begin errors++;
      $display("FAIL asr4 got %0d/%h/%b want 4/f800/0", s, bus.accout, bus.flag); end
    do_write(16'hc000);
    do_exec(10, 16'h000f, s, e);
    do_read();
    checks++; if (s !== 15 || bus.accout !== 16'h0001 || bus.flag !== 1'b1) begin errors++;
      $display("FAIL shr15 got %0d/%h/%b want 15/0001/1", s, bus.accout, bus.flag); end
  endtask

  task automatic test_busy_ignore();
    int n, e;
    do_write(16'h1234);
    do_read();
    bus.opcode = 5'h0C; bus.operand = 16'h0010; bus.exec = 1'b1;
    e = model_exec(12, 64'h10);
    tick();
    bus.exec = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 3 * W) begin
      n++;
      if (n == 3) begin
        bus.operand = 16'haaaa; bus.write = 1'b1; bus.read = 1'b1; bus.writeu = 1'b1;
        bus.exec = 1'b1; bus.opcode = 5'h01;
      end
      tick();
      if (n == 3) begin
        idle_inputs();
        checks++; if (bus.accout !== 16'(m_accout)) begin errors++;
          $display("FAIL busy_read got %h want %h", bus.accout, 16'(m_accout)); end
      end
    end
    checks++; if (n !== e) begin errors++; $display("FAIL busy_ignore_len got %0d want %0d", n, e); end
    do_read();
    checks++; if (bus.accout !== 16'h2340) begin errors++; $display("FAIL busy_ignore_acc got %h want 2340", bus.accout); end
  endtask

  task automatic test_priority();
    do_write(16'h1111);
    bus.operand = 16'h0003; bus.write = 1'b1; bus.exec = 1'b1; bus.opcode = 5'h01;
    m_acc = 3;
    tick();
    idle_inputs();
    do_read();
    checks++; if (bus.accout !== 16'h0003) begin errors++; $display("FAIL write_over_exec got %h want 0003", bus.accout); end
    bus.exec = 1'b1; bus.opcode = 5'h01;
    do_writeu(16'h00ab);
    idle_inputs();
    do_read();
    checks++; if (bus.accout !== 16'hab03) begin errors++; $display("FAIL writeu_over_exec got %h want ab03", bus.accout); end
    bus.writeu = 1'b1;
    do_write(16'h0077);
    idle_inputs();
    do_read();
    checks++; if (bus.accout !== 16'h0077) begin errors++; $display("FAIL write_over_writeu got %h want 0077", bus.accout); end
    bus.read = 1'b1; bus.exec = 1'b1; bus.opcode = 5'h01; bus.operand = 16'h0001;
    void'(model_exec(1, 1));
    tick();
    idle_inputs();
    checks++; if (bus.accout !== 16'h0077) begin errors++; $display("FAIL read_pre_update got %h want 0077", bus.accout); end
    do_read();
    checks++; if (bus.accout !== 16'h0078) begin errors++; $display("FAIL read_post_update got %h want 0078", bus.accout); end
  endtask

  task automatic test_reset_mid_mul();
    int n, s, e;
    do_write(16'h1234);
    do_read();
    bus.opcode = 5'h0C; bus.operand = 16'hffff; bus.exec = 1'b1;
    tick();
    bus.exec = 1'b0;
    n = 1;
    while (n < 7) begin n++; tick(); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.busy !== 1'b0 || bus.accout !== '0 || bus.flag !== 1'b0) begin errors++;
      $display("FAIL mid_mul_reset got busy=%b accout=%h flag=%b want 0/0000/0", bus.busy, bus.accout, bus.flag); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_exec(1, 16'h0001, s, e);
    do_read();
    checks++; if (bus.accout !== 16'h0001 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL post_reset_add got %h/%b want 0001/0", bus.accout, bus.busy); end
    do_exec(13, 16'h0000, s, e);
    do_read();
    checks++; if (bus.accout !== 16'h0000) begin errors++; $display("FAIL post_reset_hi got %h want 0000", bus.accout); end
  endtask

  task automatic test_back_to_back();
    int s, e;
    do_write(16'($urandom));
    do_exec(12, 16'($urandom), s, e);
    checks++; if (s !== e) begin errors++; $display("FAIL b2b_mul_len got %0d want %0d", s, e); end
    do_exec(10, 16'(1 + $urandom_range(14)), s, e);
    checks++; if (s !== e) begin errors++; $display("FAIL b2b_shr_len got %0d want %0d", s, e); end
    do_exec(1, 16'($urandom), s, e);
    do_exec(12, 16'($urandom), s, e);
    do_read();
    checks++; if (bus.accout !== 16'(m_acc) || bus.flag !== m_flag) begin errors++;
      $display("FAIL b2b_result got %h/%b want %h/%b", bus.accout, bus.flag, 16'(m_acc), m_flag); end
    do_exec(13, 16'h0000, s, e);
    do_read();
    checks++; if (bus.accout !== 16'(m_acc)) begin errors++;
      $display("FAIL b2b_hi got %h want %h", bus.accout, 16'(m_acc)); end
  endtask

  task automatic test_random();
    int s, e, act, opc;
    logic [W-1:0] v;
    for (int i = 0; i < 120; i++) begin
      act = int'($urandom_range(5));
      v   = 16'($urandom);
      if (act == 0) do_write(v);
      else if (act == 1) do_writeu(v);
      else begin
        opc = ($urandom_range(7) == 0) ? int'($urandom_range(31, 16)) : int'($urandom_range(15));
        do_exec(opc, v, s, e);
        checks++; if (s !== e) begin errors++; $display("FAIL rnd_len op=%0h got %0d want %0d", opc, s, e); end
      end
      do_read();
      checks++; if (bus.accout !== 16'(m_acc) || bus.flag !== m_flag) begin errors++;
        $display("FAIL rnd_state i=%0d got %h/%b want %h/%b", i, bus.accout, bus.flag, 16'(m_acc), m_flag); end
    end
  endtask

  initial begin
    test_reset();
    test_sub_inc();
    test_mul();
    test_shift();
    test_busy_ignore();
    test_priority();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
